// File: rtl/hamming_dist_seq.sv
// rtl/hamming_dist_seq.sv - multi-cycle Hamming distance compare engine (optional HD_EARLY_EXIT_EN)
module hamming_dist_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    localparam int DW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [DW-1:0]    thresh,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    D,
    output logic             Q
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] x;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    thresh_q;
    logic [IW-1:0]    idx;
    logic [DW-1:0]    chunk_pop;
    logic [DW-1:0]    sum;
    logic             last_chunk;

    function automatic logic [DW-1:0] pop_chunk(input logic [CHUNK-1:0] c);
        logic [DW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + DW'(c[i]);
        end
        return n;
    endfunction

    always_comb begin
        chunk_pop = pop_chunk(x[CHUNK-1:0]);
        sum       = acc + chunk_pop;
`ifdef HD_EARLY_EXIT_EN
        // Nothing left above the current chunk means the distance is final now.
        last_chunk = (idx == LAST_IDX) || ((x >> CHUNK) == '0);
`else
        last_chunk = (idx == LAST_IDX);
`endif
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            acc      <= '0;
            thresh_q <= '0;
            idx      <= '0;
            done     <= 1'b0;
            D        <= '0;
            Q        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x        <= A ^ B;
                        thresh_q <= thresh;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    x   <= x >> CHUNK;
                    acc <= sum;
                    idx <= idx + IW'(1);
                    if (last_chunk) begin
                        D     <= sum;
                        Q     <= (sum <= thresh_q);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_dist_seq.sv
// tb/tb_hamming_dist_seq.sv - scoreboard bench for hamming_dist_seq
module tb_hamming_dist_seq;

    localparam int W  = 32;
    localparam int DW = 6;
    localparam int N  = 8;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_DONE = 2'd2;

    typedef struct {
        int d;
        int q;
        int acc_edge;
        int lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [DW-1:0] thresh;
    logic          busy;
    logic          done;
    logic [DW-1:0] D;
    logic          Q;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [1:0] m_st;
    int   m_rem;

    hamming_dist_seq #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .thresh(thresh), .busy(busy), .done(done), .D(D), .Q(Q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int lat_of(input logic [W-1:0] x);
`ifdef HD_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < N; i++)
            if (x[i*4 +: 4] != 4'h0) l = i + 1;
        return l;
`else
        return N;
`endif
    endfunction

    // One clock of stimulus; the model predicts whether the next edge accepts.
    task automatic step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [DW-1:0] th, input int exp_d, input int exp_q);
        exp_t e;
        @(negedge clk);
        start = s; A = a; B = b; thresh = th;
        if (m_st == M_RUN) begin
            m_rem--;
            if (m_rem == 0) m_st = M_DONE;
        end else if (s) begin
            e.d = exp_d; e.q = exp_q; e.acc_edge = cyc + 1; e.lat = lat_of(a ^ b);
            sb.push_back(e);
            m_rem = e.lat;
            m_st  = M_RUN;
        end else begin
            m_st = M_IDLE;
        end
    endtask

    task automatic job(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [DW-1:0] th, input int exp_d, input int exp_q);
        step(1'b1, a, b, th, exp_d, exp_q);
        do step(1'b0, $urandom, $urandom, DW'($urandom), 0, 0);
        while (m_st != M_IDLE);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: D=%0d Q=%0d, expected no result", D, Q);
            end else begin
                mon_e = sb.pop_front();
                check("D", int'(D), mon_e.d);
                check("Q", int'(Q), mon_e.q);
                check("latency", cyc - mon_e.acc_edge, mon_e.lat);
                check("busy_with_done", int'(busy), 0);
            end
        end
    end

    logic [W-1:0]  ra, rb;
    logic [DW-1:0] rt;
    int            rd;

    initial begin
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; thresh = '0;
        m_st = M_IDLE; m_rem = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_D", int'(D), 0);
        check("reset_Q", int'(Q), 0);
        rst_n = 1'b1;

        job(32'h5, 32'h9, 6'd2, 2, 1);
        job(32'hFFFF_FFFF, 32'h0, 6'd31, 32, 0);
        job(32'hDEAD_BEEF, 32'hDEAD_BEEF, 6'd0, 0, 1);
        job(32'h0000_00FF, 32'h0, 6'd8, 8, 1);
        job(32'h0000_00FF, 32'h0, 6'd7, 8, 0);
        job(32'h8000_0000, 32'h0, 6'd0, 1, 0);
        job(32'h0000_0001, 32'h0, 6'd1, 1, 1);
        job(32'hF0F0_0F0F, 32'h0F0F_F0F0, 6'd32, 32, 1);
        job(32'hA5A5_A5A5, 32'h5A5A_0000, 6'd24, 24, 1);

        // start held high with fresh operands every cycle
        for (int i = 0; i < 30; i++) begin
            ra = $urandom; rb = $urandom; rt = DW'($urandom_range(0, 32));
            rd = $countones(ra ^ rb);
            step(1'b1, ra, rb, rt, rd, int'(rd <= int'(rt)));
        end
        do step(1'b0, '0, '0, '0, 0, 0); while (m_st != M_IDLE);

        // abort a job mid-run with an asynchronous reset
        job(32'hFFFF_FFFF, 32'h0, 6'd0, 32, 0);
        step(1'b1, 32'hFFFF_0000, 32'h0, 6'd20, 16, 1);
        repeat (3) step(1'b0, '0, '0, '0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_D", int'(D), 0);
        check("abort_Q", int'(Q), 0);
        void'(sb.pop_back());
        m_st = M_IDLE; m_rem = 0;
        @(negedge clk);
        rst_n = 1'b1;
        job(32'h0000_0003, 32'h0000_0006, 6'd2, 2, 1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = (i % 5 == 0) ? ra ^ (32'h1 << (i % 32)) : $urandom;
            rt = DW'($urandom_range(0, 32));
            rd = $countones(ra ^ rb);
            job(ra, rb, rt, rd, int'(rd <= int'(rt)));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, '0, '0, '0, 0, 0);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
